// File: rtl/univ_shift_reg_pkg.sv
// Shared types for the universal shift register.
// Op encoding and shift classification.
package shreg_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    LOAD  = 3'd1,
    SHL   = 3'd2,
    SHR   = 3'd3,
    ROTL  = 3'd4,
    ROTR  = 3'd5,
    ASHR  = 3'd6,
    CLEAR = 3'd7
  } shreg_op_e;

  function automatic logic is_shift(
    input shreg_op_e op
  );
    unique case (op)
      SHL, SHR, ROTL, ROTR, ASHR:
        is_shift = 1'b1;
      default:
        is_shift = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/univ_shift_reg_frame_cnt.sv
// Frame counter: counts shifts since the last
// load/clear and pulses frame_done every WIDTH shifts.
module shreg_frame_cnt #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  input  logic          step,
  output logic [CW-1:0] cnt,
  output logic          frame_done
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en && clr) begin
      cnt_d = '0;
    end else if (en && step) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt        = cnt_q;
  assign frame_done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with serial ends,
// parallel load/output and a frame counter.
module univ_shift_reg
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic             si_l,
  input  logic             si_r,
  input  logic [WIDTH-1:0] pi,
  output logic [WIDTH-1:0] po,
  output logic             so_msb,
  output logic             so_lsb,
  output logic [CW-1:0]    cnt,
  output logic             frame_done
);

  logic [WIDTH-1:0] q_q, q_d;
  shreg_op_e        op_e;
  logic             clr;
  logic             step;

  assign op_e = shreg_op_e'(op);

  always_comb begin
    q_d = q_q;
    if (en) begin
      unique case (op_e)
        HOLD:  q_d = q_q;
        LOAD:  q_d = pi;
        SHL:   q_d = {q_q[WIDTH-2:0], si_r};
        SHR:   q_d = {si_l, q_q[WIDTH-1:1]};
        ROTL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        ROTR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        ASHR:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        CLEAR: q_d = '0;
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign clr  = (op_e == LOAD) || (op_e == CLEAR);
  assign step = is_shift(op_e);

  shreg_frame_cnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_frame_cnt (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .clr        (clr),
    .step       (step),
    .cnt        (cnt),
    .frame_done (frame_done)
  );

  assign po     = q_q;
  assign so_msb = q_q[WIDTH-1];
  assign so_lsb = q_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: stimulus pushes
// model predictions, a monitor pops and compares.
module tb_univ_shift_reg;

  localparam int W    = 8;
  localparam int CW   = 3;
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          reset, en, si_l, si_r;
  logic [2:0]    op;
  logic [W-1:0]  pi;
  logic [W-1:0]  po;
  logic          so_msb, so_lsb, frame_done;
  logic [CW-1:0] cnt;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .op         (op),
    .si_l       (si_l),
    .si_r       (si_r),
    .pi         (pi),
    .po         (po),
    .so_msb     (so_msb),
    .so_lsb     (so_lsb),
    .cnt        (cnt),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    po;
    int    cnt;
    int    fd;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: register value and shifts in current frame
  int m_q  = 0;
  int m_sh = 0;

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(bit r, bit e, int o, bit sl, bit sr,
                       int p, string tag);
    int fd;
    int sq;
    @(negedge clk);
    reset = r;
    en    = e;
    op    = o[2:0];
    si_l  = sl;
    si_r  = sr;
    pi    = p[W-1:0];
    fd    = 0;
    if (r) begin
      m_q  = 0;
      m_sh = 0;
    end else if (e) begin
      case (o)
        1: begin m_q = p & MASK; m_sh = 0; end
        7: begin m_q = 0;        m_sh = 0; end
        0: ;
        default: begin
          case (o)
            2: m_q = ((m_q * 2) + sr) & MASK;
            3: m_q = (m_q / 2) + (sl ? (1 << (W-1)) : 0);
            4: m_q = ((m_q * 2) + (m_q >> (W-1))) & MASK;
            5: m_q = (m_q / 2) + ((m_q % 2) << (W-1));
            default: begin
              sq  = (m_q >= (1 << (W-1))) ? m_q - (1 << W) : m_q;
              sq  = (sq < 0) ? -((-sq + 1) / 2) : sq / 2;
              m_q = sq & MASK;
            end
          endcase
          m_sh++;
          if (m_sh == W) begin
            m_sh = 0;
            fd   = 1;
          end
        end
      endcase
    end
    sb.push_back('{m_q, m_sh, fd, tag});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".po"},  int'(po),         e.po);
        check({e.tag, ".cnt"}, int'(cnt),        e.cnt);
        check({e.tag, ".fd"},  int'(frame_done), e.fd);
        check({e.tag, ".msb"}, int'(so_msb),     (e.po >> (W-1)) & 1);
        check({e.tag, ".lsb"}, int'(so_lsb),     e.po & 1);
      end
    end
  end

  int sir_seq[8] = '{1, 1, 0, 1, 0, 0, 1, 0};

  initial begin : stim
    reset = 1'b1; en = 1'b0; op = 3'd0;
    si_l = 1'b0; si_r = 1'b0; pi = '0;
    drive(1, 0, 0, 0, 0, 0, "rst");
    drive(1, 0, 0, 0, 0, 0, "rst");
    // PISO
    drive(0, 1, 1, 0, 0, 'hA5, "piso_ld");
    for (int i = 0; i < 8; i++) drive(0, 1, 3, 0, 0, 0, "piso");
    drive(0, 1, 0, 0, 0, 0, "piso_hold");
    // SIPO from reset
    drive(1, 0, 0, 0, 0, 0, "rst");
    for (int i = 0; i < 8; i++)
      drive(0, 1, 2, 0, sir_seq[i][0], 0, "sipo");
    drive(0, 1, 2, 0, 1, 0, "sipo9");
    // Rotate / arithmetic
    drive(0, 1, 1, 0, 0, 'h81, "rot_ld");
    drive(0, 1, 4, 0, 0, 0, "rotl");
    drive(0, 1, 5, 0, 0, 0, "rotr");
    drive(0, 1, 5, 0, 0, 0, "rotr");
    drive(0, 1, 1, 0, 0, 'h80, "ashr_ld");
    drive(0, 1, 6, 0, 0, 0, "ashr");
    drive(0, 1, 6, 0, 0, 0, "ashr");
    // Enable pause
    drive(0, 1, 1, 0, 0, 'h3C, "en_ld");
    for (int i = 0; i < 3; i++) drive(0, 1, 2, 0, 0, 0, "en_shl");
    for (int i = 0; i < 4; i++) drive(0, 0, 2, 0, 1, 0, "en_off");
    for (int i = 0; i < 6; i++) drive(0, 1, 2, 0, 0, 0, "en_res");
    // Abort by load, then reset mid-frame
    for (int i = 0; i < 5; i++) drive(0, 1, 3, 1, 0, 0, "ab_shr");
    drive(0, 1, 1, 0, 0, 'hFF, "ab_ld");
    for (int i = 0; i < 9; i++) drive(0, 1, 3, 0, 0, 0, "ab_frm");
    for (int i = 0; i < 3; i++) drive(0, 1, 4, 0, 0, 0, "ab_rot");
    drive(1, 1, 4, 0, 0, 0, "ab_rst");
    // Priority
    drive(1, 1, 1, 0, 0, 'h55, "pri_rst");
    drive(0, 1, 1, 0, 0, 'h5A, "pri_ld");
    drive(0, 1, 2, 0, 1, 0, "pri_shl");
    drive(0, 1, 7, 0, 0, 0, "pri_clr");
    // Back-to-back frames of mixed shifts
    for (int i = 0; i < 24; i++)
      drive(0, 1, 2 + (i % 5), i % 2, i % 3 == 0, 0, "b2b");
    // Random
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 49) == 0,
            $urandom_range(0, 9) < 8,
            $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, MASK), "rnd");
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
